// File: rtl/nvm_access_arbiter.sv
// Round-robin owner arbiter for the single-port nv_memory: burst lock, starvation cap, registered command bus, tagged read return.
// Read data returns 1+MEM_RD_LATENCY cycles after the beat; define NVM_ARB_WP_EN to suppress writes below PROT_TOP (adds wp_err_o).
module nvm_access_arbiter #(
  parameter int N_REQ          = 3,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_RD_LATENCY = 1,
  parameter int MAX_BEATS      = 16,
  parameter int PROT_TOP       = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_i,
  input  logic [N_REQ-1:0]                  we_i,
  input  logic [N_REQ*MEM_ADDR_WIDTH-1:0]   addr_i,
  input  logic [N_REQ*MEM_DATA_WIDTH-1:0]   wdata_i,
  output logic [N_REQ-1:0]                  gnt_o,
  output logic [N_REQ-1:0]                  rvalid_o,
  output logic [MEM_DATA_WIDTH-1:0]         rdata_o,
  output logic                              busy_o,
  output logic                              mem_w,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0]         mem_data_o,
  input  logic [MEM_DATA_WIDTH-1:0]         mem_data_i
`ifdef NVM_ARB_WP_EN
  ,
  output logic                              wp_err_o
`endif
);

  localparam int IW = (N_REQ > 2) ? 2 : 1;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  if (N_REQ < 2 || N_REQ > 4 || MEM_RD_LATENCY < 1 || MEM_RD_LATENCY > 4 ||
      MAX_BEATS < 1 || PROT_TOP < 0) begin : g_bad_param
    $error("nvm_access_arbiter: parameter out of range");
  end

  logic [1:0]                state;
  logic [IW-1:0]             ptr;
  logic [IW-1:0]             owner;
  logic [IW-1:0]             pick;
  logic                      pick_vld;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_nxt;
  logic                      beat;
  logic                      others;
  logic                      own_we;
  logic [MEM_ADDR_WIDTH-1:0] own_addr;
  logic [MEM_DATA_WIDTH-1:0] own_wdata;
  logic [MEM_RD_LATENCY-1:0] pipe_vld;
  logic [IW-1:0]             pipe_tag [MEM_RD_LATENCY];
  logic                      pipe_busy;

  // Round-robin search starting just after the last winner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int o = 1; o <= N_REQ; o++) begin
      if (!pick_vld && req_i[(int'(ptr) + o) % N_REQ]) begin
        pick_vld = 1'b1;
        pick     = IW'((int'(ptr) + o) % N_REQ);
      end
    end
  end

  assign beat      = (state == S_OWN) && req_i[owner];
  assign others    = |(req_i & ~gnt_o);
  assign own_we    = we_i[owner];
  assign own_addr  = addr_i[int'(owner)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
  assign own_wdata = wdata_i[int'(owner)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
  assign cnt_nxt   = cnt + CW'(1);
  assign pipe_busy = |pipe_vld;
  assign busy_o    = (state != S_IDLE);
  assign rdata_o   = (|rvalid_o) ? mem_data_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= IW'(N_REQ - 1);
      owner <= '0;
      gnt_o <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt_o <= N_REQ'(1) << pick;
            owner <= pick;
            ptr   <= pick;
            cnt   <= '0;
            state <= S_OWN;
          end
        end
        S_OWN: begin
          if (!req_i[owner]) begin
            gnt_o <= '0;
            state <= S_DRAIN;
          end else if (cnt_nxt == CNT_MAX) begin
            // Window exhausted: yield only if someone else is waiting.
            cnt <= '0;
            if (others) begin
              gnt_o <= '0;
              state <= S_DRAIN;
            end
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_DRAIN: begin
          if (!pipe_busy) state <= S_IDLE;
        end
        default: begin
          gnt_o <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef NVM_ARB_WP_EN
  localparam logic [MEM_ADDR_WIDTH-1:0] PROT_ADDR = MEM_ADDR_WIDTH'(PROT_TOP);
  logic prot_hit;
  assign prot_hit = (own_addr < PROT_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_w      <= 1'b0;
      wp_err_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      mem_w    <= beat && own_we && !prot_hit;
      wp_err_o <= beat && own_we && prot_hit;
      if (beat) begin
        mem_addr_o <= own_addr;
        mem_data_o <= own_wdata;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_w      <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      mem_w <= beat && own_we;
      if (beat) begin
        mem_addr_o <= own_addr;
        mem_data_o <= own_wdata;
      end
    end
  end
`endif

  // Tag pipe tracks the command slot; rvalid lands in the cycle mem_data_i is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < MEM_RD_LATENCY; i++) pipe_tag[i] <= '0;
      rvalid_o <= '0;
    end else begin
      pipe_vld[0] <= beat && !own_we;
      pipe_tag[0] <= owner;
      for (int i = 1; i < MEM_RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      rvalid_o <= pipe_vld[MEM_RD_LATENCY-1] ? (N_REQ'(1) << pipe_tag[MEM_RD_LATENCY-1]) : '0;
    end
  end

endmodule

// File: tb/tb_nvm_access_arbiter.sv
// Bench for nvm_access_arbiter: directed vector table, hand sequences and random traffic against a transaction-level model.
module tb_nvm_access_arbiter;
  localparam int N = 3, AW = 8, DW = 32, L = 1, MB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req = '0, we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, mem_dat, mem_rd;
  logic            busy, mem_w;
  logic [AW-1:0]   mem_addr;
`ifdef NVM_ARB_WP_EN
  logic            wp_err;
  localparam logic [AW-1:0] PT = 8'h01;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nvm_access_arbiter #(.N_REQ(N), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW),
                       .MEM_RD_LATENCY(L), .MAX_BEATS(MB), .PROT_TOP(1)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy),
    .mem_w(mem_w), .mem_addr_o(mem_addr), .mem_data_o(mem_dat), .mem_data_i(mem_rd)
`ifdef NVM_ARB_WP_EN
    , .wp_err_o(wp_err)
`endif
  );

  // nv_memory stand-in: read-first, data valid L cycles after the command slot
  logic mem_init = 1'b0;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] dl [L];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | DW'(i);
    end else if (mem_w) begin
      mem[mem_addr] <= mem_dat;
    end
    dl[0] <= mem[mem_addr];
    for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
  end
  assign mem_rd = dl[L-1];

  // Transaction-level reference: owner bookkeeping plus a queue of reads due by cycle number
  typedef struct { int due; int tag; logic [DW-1:0] val; } rd_t;
  rd_t rdq[$];
  logic [DW-1:0] mmem [256];
  int m_mode, m_owner, m_ptr, m_cnt, cyc;
  logic [N-1:0]  e_gnt, e_rv;
  logic          e_mw, e_busy, e_wp;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data, e_rd;

  function automatic int first_from(int p, logic [N-1:0] r);
    for (int o = 1; o <= N; o++) if (r[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = -1; m_ptr = N - 1; m_cnt = 0;
    e_gnt = '0; e_rv = '0; e_mw = 1'b0; e_busy = 1'b0; e_wp = 1'b0;
    e_addr = '0; e_data = '0; e_rd = '0;
    rdq.delete();
  endtask

  task automatic model_edge();
    bit empty;
    int k;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    empty = (rdq.size() == 0);
    e_mw = 1'b0; e_wp = 1'b0;
    case (m_mode)
      0: begin
        k = first_from(m_ptr, req);
        if (k >= 0) begin
          m_owner = k; m_ptr = k; m_cnt = 0; m_mode = 1; e_gnt = N'(1) << k;
        end
      end
      1: begin
        if (req[m_owner]) begin
          a = addr[m_owner*AW +: AW];
          d = wdata[m_owner*DW +: DW];
          e_addr = a; e_data = d;
          if (we[m_owner]) begin
`ifdef NVM_ARB_WP_EN
            if (a < PT) e_wp = 1'b1;
            else begin e_mw = 1'b1; mmem[a] = d; end
`else
            e_mw = 1'b1; mmem[a] = d;
`endif
          end else begin
            rdq.push_back('{cyc + 1 + L, m_owner, mmem[a]});
          end
          m_cnt++;
          if (m_cnt == MB) begin
            m_cnt = 0;
            if ((req & ~e_gnt) != '0) begin m_mode = 2; e_gnt = '0; end
          end
        end else begin
          m_mode = 2; e_gnt = '0;
        end
      end
      default: if (empty) m_mode = 0;
    endcase
    e_busy = (m_mode != 0);
    e_rv = '0; e_rd = '0;
    if (rdq.size() != 0 && rdq[0].due == cyc + 1) begin
      e_rv = N'(1) << rdq[0].tag;
      e_rd = rdq[0].val;
      void'(rdq.pop_front());
    end
    cyc++;
  endtask

  task automatic check(string name);
    logic bad;
    vectors++;
    bad = (gnt !== e_gnt) || (rvalid !== e_rv) || (mem_w !== e_mw) || (busy !== e_busy) ||
          (mem_addr !== e_addr) || (rdata !== e_rd) || (e_mw && mem_dat !== e_data);
`ifdef NVM_ARB_WP_EN
    bad = bad || (wp_err !== e_wp);
`endif
    if (bad) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got gnt=%b rv=%b w=%b busy=%b addr=%h rd=%h wd=%h want gnt=%b rv=%b w=%b busy=%b addr=%h rd=%h wd=%h",
               name, cyc, gnt, rvalid, mem_w, busy, mem_addr, rdata, mem_dat,
               e_gnt, e_rv, e_mw, e_busy, e_addr, e_rd, e_data);
    end
  endtask

  task automatic tick(string name);
    model_edge();
    @(posedge clk);
    #1;
    check(name);
  endtask

  typedef struct {
    logic [N-1:0] req, we; logic [AW-1:0] a; logic [DW-1:0] wd;
    logic [N-1:0] gnt, rv; logic mw, busy; logic [AW-1:0] ma; logic [DW-1:0] rd;
  } vec_t;
  vec_t tbl [15];

  int runs, rlen, wp_seen;
  logic [N-1:0] pg;

  initial begin
    // requester 0: one write, one read, then four back-to-back reads
    tbl[0]  = '{3'b001, 3'b001, 8'h05, 32'hDEADBEEF, 3'b001, 3'b000, 1'b0, 1'b1, 8'h00, 32'h0};
    tbl[1]  = '{3'b001, 3'b001, 8'h05, 32'hDEADBEEF, 3'b001, 3'b000, 1'b1, 1'b1, 8'h05, 32'h0};
    tbl[2]  = '{3'b000, 3'b000, 8'h05, 32'h0,        3'b000, 3'b000, 1'b0, 1'b1, 8'h05, 32'h0};
    tbl[3]  = '{3'b000, 3'b000, 8'h05, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 8'h05, 32'h0};
    tbl[4]  = '{3'b001, 3'b000, 8'h05, 32'h0,        3'b001, 3'b000, 1'b0, 1'b1, 8'h05, 32'h0};
    tbl[5]  = '{3'b001, 3'b000, 8'h05, 32'h0,        3'b001, 3'b000, 1'b0, 1'b1, 8'h05, 32'h0};
    tbl[6]  = '{3'b000, 3'b000, 8'h05, 32'h0,        3'b000, 3'b001, 1'b0, 1'b1, 8'h05, 32'hDEADBEEF};
    tbl[7]  = '{3'b000, 3'b000, 8'h05, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 8'h05, 32'h0};
    tbl[8]  = '{3'b001, 3'b000, 8'h05, 32'h0,        3'b001, 3'b000, 1'b0, 1'b1, 8'h05, 32'h0};
    tbl[9]  = '{3'b001, 3'b000, 8'h05, 32'h0,        3'b001, 3'b000, 1'b0, 1'b1, 8'h05, 32'h0};
    tbl[10] = '{3'b001, 3'b000, 8'h06, 32'h0,        3'b001, 3'b001, 1'b0, 1'b1, 8'h06, 32'hDEADBEEF};
    tbl[11] = '{3'b001, 3'b000, 8'h07, 32'h0,        3'b001, 3'b001, 1'b0, 1'b1, 8'h07, 32'hA5000006};
    tbl[12] = '{3'b001, 3'b000, 8'h08, 32'h0,        3'b001, 3'b001, 1'b0, 1'b1, 8'h08, 32'hA5000007};
    tbl[13] = '{3'b000, 3'b000, 8'h08, 32'h0,        3'b000, 3'b001, 1'b0, 1'b1, 8'h08, 32'hA5000008};
    tbl[14] = '{3'b000, 3'b000, 8'h08, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 8'h08, 32'h0};

    for (int i = 0; i < 256; i++) mmem[i] = 32'hA500_0000 | DW'(i);
    mem_init = 1'b1;
    @(posedge clk);
    @(posedge clk);
    mem_init = 1'b0;
    #1;
    model_reset();
    cyc = 0;
    check("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      req = tbl[i].req; we = tbl[i].we;
      addr = '0; addr[AW-1:0] = tbl[i].a;
      wdata = '0; wdata[DW-1:0] = tbl[i].wd;
      @(posedge clk);
      #1;
      vectors++;
      if (gnt !== tbl[i].gnt || rvalid !== tbl[i].rv || mem_w !== tbl[i].mw || busy !== tbl[i].busy ||
          mem_addr !== tbl[i].ma || rdata !== tbl[i].rd || (tbl[i].mw && mem_dat !== tbl[i].wd)) begin
        miscompares++;
        $display("FAIL table[%0d] got gnt=%b rv=%b w=%b busy=%b addr=%h rd=%h wd=%h want gnt=%b rv=%b w=%b busy=%b addr=%h rd=%h wd=%h",
                 i, gnt, rvalid, mem_w, busy, mem_addr, rdata, mem_dat,
                 tbl[i].gnt, tbl[i].rv, tbl[i].mw, tbl[i].busy, tbl[i].ma, tbl[i].rd, tbl[i].wd);
      end
    end
    mmem[8'h05] = 32'hDEADBEEF;  // write issued by the table rows

    // all three requesting: 16-beat windows rotating 0,1,2,0
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    req = 3'b111; we = 3'b111;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW] = AW'(8'h10 + i);
      wdata[i*DW +: DW] = $urandom;
    end
    runs = 0; rlen = 0; pg = '0;
    for (int t = 0; t < 80; t++) begin
      tick("rr");
      if (gnt != '0) rlen++;
      else if (pg != '0) begin
        vectors++;
        if (rlen != MB || pg != (N'(1) << (runs % N))) begin
          miscompares++;
          $display("FAIL rr_window run=%0d got gnt=%b len=%0d want gnt=%b len=%0d",
                   runs, pg, rlen, N'(1) << (runs % N), MB);
        end
        runs++; rlen = 0;
      end
      pg = gnt;
    end
    vectors++;
    if (runs < 4) begin
      miscompares++;
      $display("FAIL rr_runs got %0d want >=4", runs);
    end
    req = '0;
    for (int t = 0; t < 4; t++) tick("rr_idle");

    // requester 1 alone for 40 beats, then requester 2 joins mid-window
    req = 3'b010; we = 3'b000;
    for (int t = 0; t < 41; t++) begin
      addr[AW +: AW] = AW'($urandom_range(0, 15));
      tick("hold1");
    end
    req = 3'b110;
    for (int t = 0; t < 20; t++) tick("hold1_yield");
    req = '0;
    for (int t = 0; t < 4; t++) tick("hold1_idle");

    // random traffic
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        we[i] = 1'($urandom_range(0, 1));
        addr[i*AW +: AW] = AW'($urandom_range(0, 15));
        wdata[i*DW +: DW] = $urandom;
      end
      tick("rand");
    end
    req = '0;
    for (int t = 0; t < 5; t++) tick("rand_idle");

`ifdef NVM_ARB_WP_EN
    wp_seen = 0;
    req = 3'b001; we = 3'b001; addr = '0; wdata = '0; wdata[DW-1:0] = 32'h1234_5678;
    tick("wp_gnt");
    tick("wp_blocked");
    if (wp_err === 1'b1) wp_seen++;
    addr[AW-1:0] = 8'h01;
    tick("wp_ok");
    if (wp_err === 1'b1) wp_seen++;
    req = '0;
    for (int t = 0; t < 4; t++) tick("wp_idle");
    vectors++;
    if (wp_seen != 1) begin
      miscompares++;
      $display("FAIL wp_pulses got %0d want 1", wp_seen);
    end
`endif

    // reset with a read in flight
    req = 3'b001; we = 3'b000; addr = '0; addr[AW-1:0] = 8'h05;
    tick("rst_gnt");
    tick("rst_beat");
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (gnt !== '0 || rvalid !== '0 || rdata !== '0 || busy !== 1'b0 || mem_w !== 1'b0 ||
        mem_addr !== '0 || mem_dat !== '0) begin
      miscompares++;
      $display("FAIL async_reset got gnt=%b rv=%b rd=%h busy=%b w=%b addr=%h wd=%h want all zero",
               gnt, rvalid, rdata, busy, mem_w, mem_addr, mem_dat);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    for (int t = 0; t < 3; t++) tick("rst_flush");
    req = 3'b111;
    tick("rst_regrant");
    vectors++;
    if (gnt !== 3'b001) begin
      miscompares++;
      $display("FAIL rst_first_gnt got %b want 001", gnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
